// File: rtl/xdrs_dp_pkg.sv
// Shared constants and helpers for the monitored XDRS datapath.
package xdrs_dp_pkg;

    localparam int C_DATA_BW_DEF = 32;

    // Occupancy needs one bit more than the address so that 0..DEPTH fits.
    function automatic int lvl_width(input int depth_log2);
        return depth_log2 + 1;
    endfunction

endpackage

// File: rtl/dp_mon_fifo_ram.sv
// DEPTH x C_DATA_BW storage: synchronous write, asynchronous read, no reset.
module dp_mon_fifo_ram #(
    parameter int C_DATA_BW    = 32,
    parameter int C_DEPTH_LOG2 = 3
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [C_DEPTH_LOG2-1:0] waddr,
    input  logic [C_DATA_BW-1:0]    wdata,
    input  logic [C_DEPTH_LOG2-1:0] raddr,
    output logic [C_DATA_BW-1:0]    rdata
);

    logic [C_DATA_BW-1:0] r_mem [(1 << C_DEPTH_LOG2)];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/dp_mon_fifo.sv
// First-word-fall-through valid/ready FIFO with registered push/pop monitor
// taps, occupancy, almost-full and a sticky upstream protocol-violation flag.
module dp_mon_fifo
    import xdrs_dp_pkg::*;
#(
    parameter int C_DATA_BW    = C_DATA_BW_DEF,
    parameter int C_DEPTH_LOG2 = 3,
    parameter int C_AF_THRESH  = 6
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  flush,
    input  logic [C_DATA_BW-1:0]                  s_data,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    output logic [C_DATA_BW-1:0]                  m_data,
    output logic                                  m_valid,
    input  logic                                  m_ready,
    output logic [lvl_width(C_DEPTH_LOG2)-1:0]    level,
    output logic                                  almost_full,
    output logic                                  err_unstable,
    output logic [C_DATA_BW-1:0]                  mon_din,
    output logic                                  mon_din_valid,
    output logic [C_DATA_BW-1:0]                  mon_dout,
    output logic                                  mon_dout_valid
);

    localparam int              LW      = lvl_width(C_DEPTH_LOG2);
    localparam int              DEPTH   = 1 << C_DEPTH_LOG2;
    localparam logic [LW-1:0]   C_FULL  = LW'(DEPTH);
    localparam logic [LW-1:0]   C_AF    = LW'(C_AF_THRESH);

    logic [LW-1:0]        r_wr_ptr;
    logic [LW-1:0]        r_rd_ptr;
    logic [LW-1:0]        r_level;
    logic                 r_stalled;
    logic [C_DATA_BW-1:0] r_stall_data;
    logic                 r_err;
    logic [C_DATA_BW-1:0] r_mon_din;
    logic                 r_mon_din_valid;
    logic [C_DATA_BW-1:0] r_mon_dout;
    logic                 r_mon_dout_valid;

    logic                 w_push;
    logic                 w_pop;
    logic [C_DATA_BW-1:0] w_rdata;

    // Handshake: a word moves when valid and ready are both high at a rising
    // edge. ready/valid here decode only registered level, never s_valid or
    // m_ready, so a full FIFO refuses a push even while it is being popped.
    assign s_ready = (r_level != C_FULL);
    assign m_valid = (r_level != '0);
    assign w_push  = s_valid & s_ready & ~flush;
    assign w_pop   = m_valid & m_ready & ~flush;

    dp_mon_fifo_ram #(
        .C_DATA_BW    (C_DATA_BW),
        .C_DEPTH_LOG2 (C_DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .we    (w_push),
        .waddr (r_wr_ptr[C_DEPTH_LOG2-1:0]),
        .wdata (s_data),
        .raddr (r_rd_ptr[C_DEPTH_LOG2-1:0]),
        .rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_level          <= '0;
            r_stalled        <= 1'b0;
            r_stall_data     <= '0;
            r_err            <= 1'b0;
            r_mon_din        <= '0;
            r_mon_din_valid  <= 1'b0;
            r_mon_dout       <= '0;
            r_mon_dout_valid <= 1'b0;
        end else begin
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_level  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
                case ({w_push, w_pop})
                    2'b10:   r_level <= r_level + 1'b1;
                    2'b01:   r_level <= r_level - 1'b1;
                    default: r_level <= r_level;
                endcase
            end

            // A stalled producer must hold s_valid and s_data until accepted.
            if (r_stalled && (!s_valid || (s_data != r_stall_data))) begin
                r_err <= 1'b1;
            end
            r_stalled <= ~flush & s_valid & ~s_ready;
            if (s_valid && !s_ready) begin
                r_stall_data <= s_data;
            end

            r_mon_din_valid  <= w_push;
            r_mon_dout_valid <= w_pop;
            if (w_push) r_mon_din  <= s_data;
            if (w_pop)  r_mon_dout <= w_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (r_level == LW'(r_wr_ptr - r_rd_ptr))
                else $error("level counter out of step with pointers");
        end
    end

    assign m_data         = w_rdata;
    assign level          = r_level;
    assign almost_full    = (r_level >= C_AF);
    assign err_unstable   = r_err;
    assign mon_din        = r_mon_din;
    assign mon_din_valid  = r_mon_din_valid;
    assign mon_dout       = r_mon_dout;
    assign mon_dout_valid = r_mon_dout_valid;

endmodule

// File: tb/tb_dp_mon_fifo.sv
// Scoreboard bench for dp_mon_fifo with default parameters (DEPTH = 8).
module tb_dp_mon_fifo;

    localparam int W     = 32;
    localparam int DEPTH = 8;
    localparam int AF    = 6;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic [W-1:0] s_data;
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_ready;
    logic [3:0]   level;
    logic         almost_full;
    logic         err_unstable;
    logic [W-1:0] mon_din;
    logic         mon_din_valid;
    logic [W-1:0] mon_dout;
    logic         mon_dout_valid;

    dp_mon_fifo dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .level          (level),
        .almost_full    (almost_full),
        .err_unstable   (err_unstable),
        .mon_din        (mon_din),
        .mon_din_valid  (mon_din_valid),
        .mon_dout       (mon_dout),
        .mon_dout_valid (mon_dout_valid)
    );

    // clock / reset
    always #5 clk = ~clk;

    // scoreboard and reference model state
    logic [W-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_errors = 0;
    int           m_lvl;
    logic         m_err;
    logic         m_stalled;
    logic [W-1:0] m_stall_data;
    logic [W-1:0] m_mon_din;
    logic [W-1:0] m_mon_dout;
    int           cnt_din;
    int           cnt_dout;

    always @(negedge clk) begin
        if (rst) begin
            cnt_din  <= 0;
            cnt_dout <= 0;
        end else begin
            if (mon_din_valid)  cnt_din  <= cnt_din + 1;
            if (mon_dout_valid) cnt_dout <= cnt_dout + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // driver: reset pulse, then checks every output against its reset value
    task automatic do_reset();
        rst     = 1'b1;
        flush   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();
        m_lvl = 0; m_err = 1'b0; m_stalled = 1'b0; m_stall_data = '0;
        m_mon_din = '0; m_mon_dout = '0;
        check_eq("rst_level", W'(level), 0);
        check_eq("rst_s_ready", W'(s_ready), 1);
        check_eq("rst_m_valid", W'(m_valid), 0);
        check_eq("rst_almost_full", W'(almost_full), 0);
        check_eq("rst_err", W'(err_unstable), 0);
        check_eq("rst_mon_din", mon_din, 0);
        check_eq("rst_mon_din_valid", W'(mon_din_valid), 0);
        check_eq("rst_mon_dout", mon_dout, 0);
        check_eq("rst_mon_dout_valid", W'(mon_dout_valid), 0);
        rst = 1'b0;
    endtask

    // driver: one clock cycle of stimulus; called 1 time unit after an edge
    task automatic tick(input logic sv, input logic [W-1:0] sd, input logic mr, input logic fl);
        logic push, pop;
        s_valid = sv; s_data = sd; m_ready = mr; flush = fl;
        #1;
        check_eq("s_ready", W'(s_ready), W'(m_lvl != DEPTH));
        check_eq("m_valid", W'(m_valid), W'(m_lvl != 0));
        check_eq("level", W'(level), W'(m_lvl));
        check_eq("almost_full", W'(almost_full), W'(m_lvl >= AF));
        push = sv && (m_lvl != DEPTH) && !fl;
        pop  = (m_lvl != 0) && mr && !fl;
        if (m_lvl != 0) check_eq("m_data", m_data, exp_q[0]);
        if (m_stalled && (!sv || sd != m_stall_data)) m_err = 1'b1;
        m_stalled    = !fl && sv && (m_lvl == DEPTH);
        m_stall_data = sd;
        if (pop) begin
            m_mon_dout = exp_q.pop_front();
            m_lvl--;
        end
        if (push) begin
            exp_q.push_back(sd);
            m_mon_din = sd;
            m_lvl++;
        end
        if (fl) begin
            exp_q.delete();
            m_lvl = 0;
        end
        @(posedge clk); #1;
        check_eq("mon_din_valid", W'(mon_din_valid), W'(push));
        check_eq("mon_din", mon_din, m_mon_din);
        check_eq("mon_dout_valid", W'(mon_dout_valid), W'(pop));
        check_eq("mon_dout", mon_dout, m_mon_dout);
        check_eq("err_unstable", W'(err_unstable), W'(m_err));
    endtask

    initial begin
        logic         rsv;
        logic [W-1:0] rsd;
        rst = 1'b1; flush = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        @(posedge clk);
        do_reset();

        // three pushes with the consumer stalled; m_valid shows after one cycle
        tick(1, 32'h11, 0, 0);
        tick(1, 32'h22, 0, 0);
        tick(1, 32'h33, 0, 0);
        tick(0, 0, 0, 0);

        // fill to full, ninth word refused while the head pops
        do_reset();
        for (int i = 0; i < DEPTH; i++) tick(1, 32'hA0 + W'(i), 0, 0);
        tick(1, 32'hA8, 1, 0);
        tick(1, 32'hA8, 0, 0);
        for (int i = 0; i < DEPTH; i++) tick(0, 0, 1, 0);
        tick(0, 0, 0, 0);

        // steady-state streaming at level 4 across pointer wrap
        do_reset();
        for (int i = 0; i < 4; i++) tick(1, 32'hC0 + W'(i), 0, 0);
        for (int i = 0; i < 20; i++) tick(1, $urandom, 1, 0);
        tick(0, 0, 0, 0);
        check_eq("pulse_balance", W'(cnt_din - cnt_dout), W'(m_lvl));

        // upstream changes data during a stall, flag survives flush
        do_reset();
        for (int i = 0; i < DEPTH; i++) tick(1, 32'hB0 + W'(i), 0, 0);
        tick(1, 32'h55, 0, 0);
        tick(1, 32'h56, 0, 0);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 0);
        do_reset();

        // flush at level 5 with the consumer ready
        for (int i = 0; i < 5; i++) tick(1, 32'hD0 + W'(i), 0, 0);
        tick(0, 0, 1, 1);
        tick(0, 0, 1, 0);

        // reset mid-stream, then a fresh word appears one cycle later
        for (int i = 0; i < 3; i++) tick(1, 32'hE0 + W'(i), 0, 0);
        do_reset();
        tick(1, 32'h77, 0, 0);
        tick(0, 0, 1, 0);
        tick(0, 0, 0, 0);

        // random traffic with a well-behaved producer
        do_reset();
        for (int i = 0; i < 60; i++) begin
            if (m_stalled) begin
                rsv = 1'b1; rsd = m_stall_data;
            end else begin
                rsv = 1'($urandom_range(0, 1));
                rsd = $urandom;
            end
            tick(rsv, rsd, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 29) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dp_mon_fifo.md
Name: dp_mon_fifo

Overview:
Buffering stage on the monitored XDRS datapath, directly upstream of stat_cnt. It is a valid/ready first-word-fall-through FIFO between the producer and the reconfigurable consumer. It exports registered monitor taps (din/din_valid on accepted pushes, dout/dout_valid on accepted pops) that feed stat_cnt's din, din_valid, dout and dout_valid ports without modification. It also provides occupancy, almost-full and a sticky upstream protocol-violation flag.

Parameters:
C_DATA_BW, 32, width of datapath words and monitor taps.
C_DEPTH_LOG2, 3, log2 of the FIFO depth (DEPTH = 8 by default); legal range 1..8.
C_AF_THRESH, 6, level at or above which almost_full asserts; legal range 1..DEPTH.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
flush  in  1  synchronous clear of FIFO contents; does not clear err_unstable.
s_data  in  C_DATA_BW  upstream data.
s_valid  in  1  upstream data valid.
s_ready  out  1  FIFO can accept a word.
m_data  out  C_DATA_BW  head-of-FIFO data.
m_valid  out  1  FIFO non-empty.
m_ready  in  1  downstream accepts the head word.
level  out  C_DEPTH_LOG2+1  current occupancy, 0..DEPTH.
almost_full  out  1  level >= C_AF_THRESH.
err_unstable  out  1  sticky upstream protocol violation.
mon_din  out  C_DATA_BW  last pushed word (registered); connects to stat_cnt din.
mon_din_valid  out  1  one-cycle pulse, one cycle after each push.
mon_dout  out  C_DATA_BW  last popped word (registered); connects to stat_cnt dout.
mon_dout_valid  out  1  one-cycle pulse, one cycle after each pop.

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high; it takes priority over every other input.
- Reset state: pointers = 0, level = 0, s_ready = 1, m_valid = 0, almost_full = 0, err_unstable = 0, mon_* = 0. m_data is don't-care while m_valid = 0.
- Push condition: push = s_valid & s_ready & ~flush. Pop condition: pop = m_valid & m_ready & ~flush.
- Ready and valid: s_ready = (level != DEPTH). m_valid = (level != 0). Both are decoded from registered state, so there is no combinational path from s_valid or m_ready.
- Full and empty boundaries:
  - When full, s_ready = 0 even if m_ready = 1 in the same cycle. There is no pass-through.
  - When empty, a push is not visible at m_valid until the next cycle. Write-to-read latency is 1 cycle.
- Pointers: wr_ptr and rd_ptr are C_DEPTH_LOG2+1 bits wide and wrap modulo 2*DEPTH. level = wr_ptr - rd_ptr, kept as a registered counter.
  - Simultaneous push and pop: level is unchanged and both pointers advance.
- m_data: combinational read of mem[rd_ptr[C_DEPTH_LOG2-1:0]]. It stays stable while m_valid = 1 and m_ready = 0.
- flush:
  - In the flush cycle, pointers and level go to 0 on the next edge and push/pop are suppressed.
  - mon_*_valid read 0 in the following cycle. mon_din and mon_dout hold their old values.
  - err_unstable is unaffected.
- Monitor taps: on push, the next edge sets mon_din <= s_data and mon_din_valid <= 1; otherwise mon_din_valid <= 0. mon_dout and mon_dout_valid follow the same rule on pop, with mon_dout <= m_data.
- Protocol check on the upstream side:
  - A stall is a cycle with s_valid = 1 and s_ready = 0.
  - Register a "stalled" flag and the stalled data.
  - If the cycle after a stall has s_valid = 0, or s_data differs from the stalled data, set err_unstable. The flag stays set until rst.
  - flush clears the stalled flag.
- Reset mid-operation: the next edge returns every output to its reset value and drops any data held in the FIFO.

Decomposition:
- Package xdrs_dp_pkg holds C_DATA_BW default and a function computing the level width (C_DEPTH_LOG2+1).
- One sub-module, dp_mon_fifo_ram: DEPTH x C_DATA_BW array with a synchronous write port (we, waddr, wdata) and an asynchronous read port (raddr, rdata), no reset.
- Pointer logic, level, protocol check and monitor registers stay in dp_mon_fifo.

Test Plan:
1. Reset, then push 0x11,0x22,0x33 on consecutive cycles with m_ready = 0 → level = 3. mon_din_valid pulses on cycles 2..4 with mon_din = 0x11,0x22,0x33. m_valid rises 1 cycle after the first push and m_data = 0x11.
2. Push 8 words 0xA0..0xA7 (default params) → level = 8, s_ready = 0, almost_full = 1 from level 6. A ninth s_valid with m_ready = 1 pops 0xA0 only and the push is not accepted. Next cycle level = 7 and s_ready = 1.
3. Hold level = 4 with s_valid = m_ready = 1 for 20 cycles → level stays 4. Pointers wrap, and the output sequence equals the input sequence in order. The cumulative count of mon_din_valid pulses equals the count of mon_dout_valid pulses plus 4.
4. Fill to 8, then raise s_valid = 1 with data 0x55 for one stall cycle, then 0x56 → err_unstable = 1. It stays 1 through a later flush and clears only after rst.
5. Pulse flush while level = 5 and m_ready = 1 → next cycle level = 0, m_valid = 0, s_ready = 1, and no mon_dout_valid pulse occurs for that cycle.
6. Assert rst mid-stream at level = 3 → next cycle every output is at its reset value. A subsequent push of 0x77 appears at m_data one cycle later.
